// File: rtl/reg_file_param.sv
// reg_file_param: 2R/1W register file with registered reads and a zeroing sweep FSM (optional REGFILE_BYPASS_EN write-through)
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WR3,
  input  logic              writeRegister,
  input  logic              clear,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic              ready
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1, rd2;
  logic wr_ok, last;
  assign last  = int'(count) == DEPTH - 1;
  assign ready = state == READY;
  assign wr_ok = state == READY && writeRegister && !clear && int'(A3) < DEPTH &&
                 !(ZERO_REG != 0 && A3 == '0);
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if (state == CLEAR || int'(a) >= DEPTH || (ZERO_REG != 0 && a == '0)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && a == A3) return WR3;
`endif
    return mem[a];
  endfunction
  // read-port values as seen at the coming edge
  always_comb begin
    rd1 = rd(A1);
    rd2 = rd(A2);
  end
  // sweep finishes on the last entry; clear from READY restarts it
  always_comb begin
    state_nxt = state;
    state_nxt = state == CLEAR ? (last ? READY : CLEAR) : (clear ? CLEAR : READY);
  end
  // state register
  always_ff @(posedge clock)
    if (reset) state <= CLEAR;
    else state <= state_nxt;
  // sweep counter and registered read data
  always_ff @(posedge clock)
    if (reset) begin
      count <= '0;
      R1    <= '0;
      R2    <= '0;
    end else begin
      count <= state == CLEAR ? count + 1'b1 : (state_nxt == CLEAR ? '0 : count);
      R1    <= rd1;
      R2    <= rd2;
    end
  // storage: sweep zeroing or an accepted write
  always_ff @(posedge clock)
    if (!reset) begin
      if (state == CLEAR) mem[count] <= '0;
      else if (wr_ok) mem[A3] <= WR3;
    end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed-vector bench for reg_file_param
module tb_reg_file_param;
  logic        clock = 0;
  logic        reset = 1;
  logic [4:0]  A1 = 0, A2 = 0, A3 = 0;
  logic [31:0] WR3 = 0;
  logic        writeRegister = 0, clear = 0;
  logic [31:0] R1, R2;
  logic        ready;
  int vectors = 0, miscompares = 0;

  reg_file_param dut (
    .clock(clock), .reset(reset), .A1(A1), .A2(A2), .A3(A3), .WR3(WR3),
    .writeRegister(writeRegister), .clear(clear), .R1(R1), .R2(R2), .ready(ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    A3 = a; WR3 = d; writeRegister = 1;
  endtask

  initial begin
    step; step;
    check("reset_r1", R1, 0);
    check("reset_r2", R2, 0);
    check("reset_ready", {31'b0, ready}, 0);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      A1 = 5'(i); A2 = 5'(i);
      step;
      check("sweep_ready", {31'b0, ready}, i == 32 ? 1 : 0);
    end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      step;
      check("init_r1", R1, 0);
      check("init_r2", R2, 0);
    end
    // basic write then read
    write(5, 874);
    step;
    writeRegister = 0; A1 = 5; A2 = 5;
    step;
    check("wr5_r1", R1, 874);
    check("wr5_r2_same", R2, 874);
    A3 = 5; WR3 = 8;
    step;
    check("nowe_r1", R1, 874);
    // same-edge read of the written address
    write(20, 83948); A2 = 20;
    step;
`ifdef REGFILE_BYPASS_EN
    check("bypass_r2", R2, 83948);
`else
    check("nobypass_r2", R2, 0);
`endif
    writeRegister = 0;
    step;
    check("later_r2", R2, 83948);
    // zero register ignores writes, even with bypass
    write(0, 32'hFFFF_FFFF); A1 = 0; A2 = 0;
    step;
    check("zero_same_edge", R1, 0);
    writeRegister = 0;
    step;
    check("zero_r1", R1, 0);
    check("zero_r2", R2, 0);
    // reg 7 holds a value before clearing
    write(7, 32'h1234);
    step;
    writeRegister = 0; A1 = 7;
    step;
    check("wr7_r1", R1, 32'h1234);
    // clear with coincident write, mid-sweep clear ignored, write during sweep dropped
    write(9, 32'h5555); clear = 1;
    step;
    clear = 0; writeRegister = 0;
    check("clear_ready", {31'b0, ready}, 0);
    check("clear_r1", R1, 32'h1234);
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) write(3, 32'hABCD);
      if (i == 10) clear = 1;
      step;
      clear = 0; writeRegister = 0;
      check("reclear_ready", {31'b0, ready}, i == 32 ? 1 : 0);
    end
    A1 = 7; A2 = 3;
    step;
    check("cleared_r7", R1, 0);
    check("dropped_r3", R2, 0);
    A1 = 9; A2 = 5;
    step;
    check("cleared_r9", R1, 0);
    check("cleared_r5", R2, 0);
    // reset in the middle of a sweep restarts it
    write(12, 32'h77); A1 = 12;
    step;
    writeRegister = 0;
    step;
    check("wr12_r1", R1, 32'h77);
    clear = 1;
    step;
    clear = 0;
    for (int i = 0; i < 10; i++) step;
    check("mid_ready", {31'b0, ready}, 0);
    reset = 1;
    step;
    check("rst_mid_ready", {31'b0, ready}, 0);
    check("rst_mid_r1", R1, 0);
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      step;
      check("restart_ready", {31'b0, ready}, i == 32 ? 1 : 0);
    end
    step;
    check("post_reset_r12", R1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
